ps2_keystroke_filter: RTL and testbench

PS2_KEYSTROKE_FILTER -- requirements
Module: ps2_keystroke_filter

---
 rtl/ps2_keystroke_filter_pkg.sv | 28 ++
 rtl/ps2_keystroke_filter_if.sv | 26 ++
 rtl/ps2_keystroke_filter_key_event_fifo.sv | 66 ++++++
 rtl/ps2_keystroke_filter.sv | 132 +++++++++++++
 tb/tb_ps2_keystroke_filter.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/ps2_keystroke_filter_pkg.sv
// Shared scan-code constants and decoder state encoding for the PS/2 keystroke filter.
package ps2_keystroke_filter_pkg;

    localparam logic [7:0] ScE0 = 8'hE0;
    localparam logic [7:0] ScE1 = 8'hE1;
    localparam logic [7:0] ScF0 = 8'hF0;

    // Pause/Break sends E1 followed by seven more bytes that carry no usable key.
    localparam int unsigned SkipW = 3;
    localparam logic [SkipW-1:0] E1SkipLen = 3'd7;

    typedef enum logic [2:0] {
        StIdle,
        StExt,
        StBrk,
        StExtBrk,
        StSkip
    } dec_state_e;

    // Controller responses and error bytes that never represent a key.
    function automatic logic is_discard(input logic [7:0] b);
        case (b)
            8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFD, 8'hFE, 8'hFF: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/ps2_keystroke_filter_if.sv
// Byte-in / key-event-out bundle between the PS/2 receiver, the filter and its consumer.
interface ps2_keystroke_filter_if #(
    parameter int unsigned FIFO_DEPTH = 4
);
    localparam int unsigned CntW = $clog2(FIFO_DEPTH) + 1;

    logic [7:0]      ps2_data;
    logic            ps2_data_en;
    logic            key_valid;
    logic [7:0]      key_code;
    logic            key_extended;
    logic            key_ready;
    logic            overflow;
    logic [CntW-1:0] fifo_count;

    modport master (
        output ps2_data, ps2_data_en, key_ready,
        input  key_valid, key_code, key_extended, overflow, fifo_count
    );

    modport slave (
        input  ps2_data, ps2_data_en, key_ready,
        output key_valid, key_code, key_extended, overflow, fifo_count
    );

endinterface

// File: rtl/ps2_keystroke_filter_key_event_fifo.sv
// Small synchronous FIFO for decoded key events with a sticky drop flag.
module key_event_fifo #(
    parameter int unsigned Width = 9,
    parameter int unsigned Depth = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push_i,
    input  logic [Width-1:0]       data_i,
    input  logic                   pop_i,
    output logic [Width-1:0]       data_o,
    output logic                   valid_o,
    output logic [$clog2(Depth):0] count_o,
    output logic                   overflow_o
);
    localparam int unsigned PtrW = $clog2(Depth);
    localparam logic [PtrW:0] FullCnt = (PtrW + 1)'(Depth);

    logic [Width-1:0] mem_q [Depth];
    logic [PtrW-1:0]  wptr_q, wptr_d, rptr_q, rptr_d;
    logic [PtrW:0]    count_q, count_d;
    logic             ovf_q, ovf_d;
    logic             do_push, do_pop, empty;

    always_comb begin
        empty   = (count_q == '0);
        do_pop  = pop_i && !empty;
        // A pop in the same cycle frees the slot a full-FIFO push needs.
        do_push = push_i && ((count_q != FullCnt) || do_pop);
        ovf_d   = ovf_q || (push_i && !do_push);
        wptr_d  = do_push ? wptr_q + 1'b1 : wptr_q;
        rptr_d  = do_pop ? rptr_q + 1'b1 : rptr_q;
        count_d = count_q;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wptr_q] <= data_i;
        end
    end

    assign data_o     = empty ? '0 : mem_q[rptr_q];
    assign valid_o    = !empty;
    assign count_o    = count_q;
    assign overflow_o = ovf_q;

endmodule

// File: rtl/ps2_keystroke_filter.sv
// PS/2 scan-code decoder: turns set-2 byte streams into queued key-press events.
module ps2_keystroke_filter
    import ps2_keystroke_filter_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH      = 4,
    parameter int unsigned SUPPRESS_REPEAT = 1
) (
    input logic                    clk,
    input logic                    reset,
    ps2_keystroke_filter_if.slave  bus_io
);
    dec_state_e       state_q, state_d;
    logic [SkipW-1:0] skip_q, skip_d;
    logic [7:0]       held_code_q, held_code_d;
    logic             held_ext_q, held_ext_d;
    logic             held_valid_q, held_valid_d;

    logic             make, make_ext, brk, brk_ext, held_match, push;
    logic [7:0]       byte_in;

    logic [8:0]                    fifo_data;
    logic                          fifo_valid;
    logic [$clog2(FIFO_DEPTH):0]   fifo_count;
    logic                          fifo_ovf;

    always_comb begin
        state_d      = state_q;
        skip_d       = skip_q;
        held_code_d  = held_code_q;
        held_ext_d   = held_ext_q;
        held_valid_d = held_valid_q;
        make         = 1'b0;
        make_ext     = 1'b0;
        brk          = 1'b0;
        brk_ext      = 1'b0;
        push         = 1'b0;
        byte_in      = bus_io.ps2_data;

        if (bus_io.ps2_data_en) begin
            unique case (state_q)
                StIdle: begin
                    if (byte_in == ScE0) begin
                        state_d = StExt;
                    end else if (byte_in == ScF0) begin
                        state_d = StBrk;
                    end else if (byte_in == ScE1) begin
                        state_d = StSkip;
                        skip_d  = E1SkipLen;
                    end else if (!is_discard(byte_in)) begin
                        make = 1'b1;
                    end
                end
                StExt: begin
                    if (byte_in == ScF0) begin
                        state_d = StExtBrk;
                    end else if (byte_in != ScE0 && byte_in != ScE1) begin
                        make     = 1'b1;
                        make_ext = 1'b1;
                        state_d  = StIdle;
                    end
                end
                StBrk: begin
                    brk     = 1'b1;
                    state_d = StIdle;
                end
                StExtBrk: begin
                    brk     = 1'b1;
                    brk_ext = 1'b1;
                    state_d = StIdle;
                end
                StSkip: begin
                    if (skip_q <= SkipW'(1)) begin
                        skip_d  = '0;
                        state_d = StIdle;
                    end else begin
                        skip_d = skip_q - 1'b1;
                    end
                end
                default: state_d = StIdle;
            endcase
        end

        held_match = held_valid_q && (held_code_q == byte_in);
        if (make && !((SUPPRESS_REPEAT != 0) && held_match && (held_ext_q == make_ext))) begin
            push         = 1'b1;
            held_code_d  = byte_in;
            held_ext_d   = make_ext;
            held_valid_d = 1'b1;
        end
        if (brk && held_match && (held_ext_q == brk_ext)) begin
            held_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StIdle;
            skip_q       <= '0;
            held_code_q  <= '0;
            held_ext_q   <= 1'b0;
            held_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            skip_q       <= skip_d;
            held_code_q  <= held_code_d;
            held_ext_q   <= held_ext_d;
            held_valid_q <= held_valid_d;
        end
    end

    key_event_fifo #(
        .Width (9),
        .Depth (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .push_i     (push),
        .data_i     ({make_ext, byte_in}),
        .pop_i      (bus_io.key_valid && bus_io.key_ready),
        .data_o     (fifo_data),
        .valid_o    (fifo_valid),
        .count_o    (fifo_count),
        .overflow_o (fifo_ovf)
    );

    assign bus_io.key_valid    = fifo_valid;
    assign bus_io.key_code     = fifo_data[7:0];
    assign bus_io.key_extended = fifo_data[8];
    assign bus_io.fifo_count   = fifo_count;
    assign bus_io.overflow     = fifo_ovf;

endmodule

// File: tb/tb_ps2_keystroke_filter.sv
// Drives two filters (repeat suppression on/off) with directed and random byte streams.
module tb_ps2_keystroke_filter;
    localparam int unsigned Depth = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    ps2_keystroke_filter_if #(.FIFO_DEPTH(Depth)) if_sr ();
    ps2_keystroke_filter_if #(.FIFO_DEPTH(Depth)) if_nr ();

    ps2_keystroke_filter #(.FIFO_DEPTH(Depth), .SUPPRESS_REPEAT(1)) dut_sr (
        .clk    (clk),
        .reset  (reset),
        .bus_io (if_sr.slave)
    );

    ps2_keystroke_filter #(.FIFO_DEPTH(Depth), .SUPPRESS_REPEAT(0)) dut_nr (
        .clk    (clk),
        .reset  (reset),
        .bus_io (if_nr.slave)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: index 0 suppresses repeats, index 1 does not.
    bit         m_e0   [2];
    bit         m_f0   [2];
    int         m_skip [2];
    logic [7:0] m_hcode[2];
    bit         m_hext [2];
    bit         m_hval [2];
    bit         m_ovf  [2];
    logic [8:0] q0[$];
    logic [8:0] q1[$];
    int         dut_pops[2];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_e0[k] = 0; m_f0[k] = 0; m_skip[k] = 0;
            m_hcode[k] = '0; m_hext[k] = 0; m_hval[k] = 0; m_ovf[k] = 0;
        end
        q0.delete();
        q1.delete();
    endtask

    task automatic model_byte(input int k, input logic [7:0] b, output bit emit,
                              output logic [8:0] ev);
        bit mk  = 0;
        bit ext = 0;
        emit = 0;
        ev   = '0;
        if (m_skip[k] > 0) begin
            m_skip[k]--;
        end else if (m_f0[k]) begin
            if (m_hval[k] && m_hcode[k] == b && m_hext[k] == m_e0[k]) m_hval[k] = 0;
            m_f0[k] = 0;
            m_e0[k] = 0;
        end else if (b == 8'hF0) begin
            m_f0[k] = 1;
        end else if (m_e0[k]) begin
            if (b != 8'hE0 && b != 8'hE1) begin
                mk = 1; ext = 1; m_e0[k] = 0;
            end
        end else if (b == 8'hE0) begin
            m_e0[k] = 1;
        end else if (b == 8'hE1) begin
            m_skip[k] = 7;
        end else if (!(b inside {8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFD, 8'hFE, 8'hFF})) begin
            mk = 1;
        end
        if (mk && !(k == 0 && m_hval[k] && m_hcode[k] == b && m_hext[k] == ext)) begin
            emit = 1;
            ev = {ext, b};
            m_hcode[k] = b; m_hext[k] = ext; m_hval[k] = 1;
        end
    endtask

    task automatic check_all(input string tag);
        logic [8:0] h0, h1;
        h0 = (q0.size() > 0) ? q0[0] : 9'h000;
        h1 = (q1.size() > 0) ? q1[0] : 9'h000;
        check({tag, " sr.valid"}, 32'(if_sr.key_valid), 32'(q0.size() > 0));
        check({tag, " sr.code"},  32'(if_sr.key_code), 32'(h0[7:0]));
        check({tag, " sr.ext"},   32'(if_sr.key_extended), 32'(h0[8]));
        check({tag, " sr.count"}, 32'(if_sr.fifo_count), 32'(q0.size()));
        check({tag, " sr.ovf"},   32'(if_sr.overflow), 32'(m_ovf[0]));
        check({tag, " nr.valid"}, 32'(if_nr.key_valid), 32'(q1.size() > 0));
        check({tag, " nr.code"},  32'(if_nr.key_code), 32'(h1[7:0]));
        check({tag, " nr.ext"},   32'(if_nr.key_extended), 32'(h1[8]));
        check({tag, " nr.count"}, 32'(if_nr.fifo_count), 32'(q1.size()));
        check({tag, " nr.ovf"},   32'(if_nr.overflow), 32'(m_ovf[1]));
    endtask

    // One clock: apply inputs, advance the model, then compare after the edge.
    task automatic step(input string tag, input logic [7:0] b, input logic en, input logic rdy);
        bit emit;
        logic [8:0] ev;
        bit pop;
        if_sr.ps2_data = b; if_sr.ps2_data_en = en; if_sr.key_ready = rdy;
        if_nr.ps2_data = b; if_nr.ps2_data_en = en; if_nr.key_ready = rdy;
        if (if_sr.key_valid && rdy) dut_pops[0]++;
        if (if_nr.key_valid && rdy) dut_pops[1]++;
        pop = (q0.size() > 0) && rdy;
        if (pop) void'(q0.pop_front());
        if (en) begin
            model_byte(0, b, emit, ev);
            if (emit) begin
                if (q0.size() < Depth) q0.push_back(ev);
                else m_ovf[0] = 1;
            end
        end
        pop = (q1.size() > 0) && rdy;
        if (pop) void'(q1.pop_front());
        if (en) begin
            model_byte(1, b, emit, ev);
            if (emit) begin
                if (q1.size() < Depth) q1.push_back(ev);
                else m_ovf[1] = 1;
            end
        end
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic do_reset(input string tag, input logic en, input logic [7:0] b);
        reset = 1'b1;
        if_sr.ps2_data = b; if_sr.ps2_data_en = en; if_sr.key_ready = 1'b1;
        if_nr.ps2_data = b; if_nr.ps2_data_en = en; if_nr.key_ready = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;
        check_all(tag);
    endtask

    task automatic send(input string tag, input logic [7:0] bytes[$], input logic rdy);
        foreach (bytes[i]) step(tag, bytes[i], 1'b1, rdy);
    endtask

    initial begin
        logic [7:0] seq[$];
        logic [7:0] pool[$];
        reset = 1'b1;
        if_sr.ps2_data = '0; if_sr.ps2_data_en = 1'b0; if_sr.key_ready = 1'b0;
        if_nr.ps2_data = '0; if_nr.ps2_data_en = 1'b0; if_nr.key_ready = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        check_all("reset_state");
        do_reset("reset_en_ignored", 1'b1, 8'h1C);

        // Make, break, make-code-after-break yields one event with latency 1.
        step("req33_make", 8'h1C, 1'b1, 1'b1);
        check("req33 valid_after_1", 32'(if_sr.key_valid), 32'd1);
        check("req33 code", 32'(if_sr.key_code), 32'h1C);
        seq = '{8'hF0, 8'h1C};
        send("req33", seq, 1'b1);
        step("req33_idle", 8'h00, 1'b0, 1'b1);

        // Extended make/break, then the same key again must not be treated as a repeat.
        step("req34_e0", 8'hE0, 1'b1, 1'b0);
        step("req34_75", 8'h75, 1'b1, 1'b0);
        check("req34 ext", 32'(if_sr.key_extended), 32'd1);
        check("req34 code", 32'(if_sr.key_code), 32'h75);
        seq = '{8'hE0, 8'hF0, 8'h75, 8'hE0, 8'h75};
        send("req34", seq, 1'b0);
        check("req34 held_cleared", 32'(if_sr.fifo_count), 32'd2);
        do_reset("req34_rst", 1'b0, 8'h00);

        // Typematic repeat suppression versus pass-through.
        dut_pops[0] = 0; dut_pops[1] = 0;
        seq = '{8'h1C, 8'h1C, 8'h1C, 8'hF0, 8'h1C, 8'h1C};
        send("req35", seq, 1'b1);
        repeat (3) step("req35_drain", 8'h00, 1'b0, 1'b1);
        check("req35 sr_events", 32'(dut_pops[0]), 32'd2);
        check("req35 nr_events", 32'(dut_pops[1]), 32'd4);

        // Pause sequence and controller chatter produce no events.
        do_reset("req36_rst", 1'b0, 8'h00);
        seq = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77, 8'hAA, 8'hFA};
        send("req36_skip", seq, 1'b0);
        check("req36 empty", 32'(if_sr.fifo_count), 32'd0);
        step("req36_2d", 8'h2D, 1'b1, 1'b0);
        check("req36 count", 32'(if_sr.fifo_count), 32'd1);
        check("req36 code", 32'(if_sr.key_code), 32'h2D);

        // Overflow with distinct makes, then drain in order.
        do_reset("req37_rst", 1'b0, 8'h00);
        seq = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        send("req37_fill", seq, 1'b0);
        check("req37 count", 32'(if_sr.fifo_count), 32'd4);
        check("req37 ovf", 32'(if_sr.overflow), 32'd1);
        seq = '{8'h11, 8'h22, 8'h33, 8'h44};
        foreach (seq[i]) begin
            check("req37 drain_code", 32'(if_sr.key_code), 32'(seq[i]));
            step("req37_drain", 8'h00, 1'b0, 1'b1);
        end
        check("req37 drained", 32'(if_sr.key_valid), 32'd0);

        // Push into a full FIFO while popping keeps the count and leaves overflow clear.
        do_reset("req38_rst", 1'b0, 8'h00);
        seq = '{8'h15, 8'h16, 8'h17, 8'h18};
        send("req38_fill", seq, 1'b0);
        step("req38_pushpop", 8'h19, 1'b1, 1'b1);
        check("req38 count", 32'(if_sr.fifo_count), 32'd4);
        check("req38 ovf", 32'(if_sr.overflow), 32'd0);
        check("req38 head", 32'(if_sr.key_code), 32'h16);
        step("req38_e0", 8'hE0, 1'b1, 1'b1);
        do_reset("req38_midrst", 1'b0, 8'h00);
        step("req38_1c", 8'h1C, 1'b1, 1'b0);
        check("req38 code", 32'(if_sr.key_code), 32'h1C);
        check("req38 ext", 32'(if_sr.key_extended), 32'd0);

        // Randomised streams, with occasional resets.
        pool = '{8'h1C, 8'h1D, 8'h75, 8'h2D, 8'h14, 8'h77, 8'hE0, 8'hE0, 8'hF0, 8'hF0,
                 8'hF0, 8'hE1, 8'hAA, 8'hFA, 8'h00};
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 99) == 0) begin
                do_reset("rand_rst", 1'($urandom_range(0, 1)), pool[$urandom_range(0, 14)]);
            end else begin
                step("rand", pool[$urandom_range(0, 14)], 1'($urandom_range(0, 2) != 0),
                     1'($urandom_range(0, 4) < 3));
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
